// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration scheduler: loads the three soft-symbol banks, then
// alternates natural/interleaved SISO half-iterations until early stop or MAX_ITER.
module turbo_iter_ctrl #(
    parameter int K        = 16,
    parameter int ADDR_W   = 4,
    parameter int MAX_ITER = 16,
    parameter int MIN_ITER = 2,
    parameter int ILV_P    = 5,
    parameter int ILV_OFS  = 3,
    parameter int ITER_W   = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_data_valid,
    input  logic              i_siso_done,
    input  logic              i_hard_match,
    output logic              o_busy,
    output logic              o_load_en,
    output logic [1:0]        o_load_bank,
    output logic [ADDR_W-1:0] o_load_addr,
    output logic              o_siso_en,
    output logic              o_siso_sel,
    output logic [ADDR_W-1:0] o_siso_addr,
    output logic [ITER_W-1:0] o_iter_cnt,
    output logic              o_done,
    output logic              o_early
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HALF1,
        S_WAIT1,
        S_HALF2,
        S_WAIT2,
        S_OUT
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] PI_STEP   = ADDR_W'(ILV_P);
    localparam logic [ADDR_W-1:0] PI_START  = ADDR_W'(ILV_OFS);
    localparam logic [ITER_W-1:0] ITER_MIN  = ITER_W'(MIN_ITER);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

    state_t              state_q, state_d;
    logic [1:0]          bank_q, bank_d;
    logic [ADDR_W-1:0]   laddr_q, laddr_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]   pi_q, pi_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                early_q, early_d;
    logic [ITER_W-1:0]   iter_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            bank_q  <= '0;
            laddr_q <= '0;
            k_q     <= '0;
            pi_q    <= '0;
            iter_q  <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            laddr_q <= laddr_d;
            k_q     <= k_d;
            pi_q    <= pi_d;
            iter_q  <= iter_d;
            early_q <= early_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        laddr_d  = laddr_q;
        k_d      = k_q;
        pi_d     = pi_q;
        iter_d   = iter_q;
        early_d  = early_q;
        iter_nxt = iter_q + ITER_W'(1);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    bank_d  = '0;
                    laddr_d = '0;
                    iter_d  = '0;
                    early_d = 1'b0;
                end
            end
            S_LOAD: begin
                // bank/addr form count = bank*K + addr, so no divider is needed
                if (i_data_valid) begin
                    if (laddr_q == ADDR_LAST) begin
                        laddr_d = '0;
                        if (bank_q == 2'd2) begin
                            state_d = S_HALF1;
                            k_d     = '0;
                        end else begin
                            bank_d = bank_q + 2'd1;
                        end
                    end else begin
                        laddr_d = laddr_q + ADDR_W'(1);
                    end
                end
            end
            S_HALF1: begin
                k_d = k_q + ADDR_W'(1);
                if (k_q == ADDR_LAST) begin
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (i_siso_done) begin
                    state_d = S_HALF2;
                    k_d     = '0;
                    pi_d    = PI_START;
                end
            end
            S_HALF2: begin
                // pi(k+1) = pi(k) + P wraps mod K because K is a power of two
                k_d  = k_q + ADDR_W'(1);
                pi_d = pi_q + PI_STEP;
                if (k_q == ADDR_LAST) begin
                    state_d = S_WAIT2;
                end
            end
            S_WAIT2: begin
                if (i_siso_done) begin
                    iter_d = iter_nxt;
                    if (i_hard_match && (iter_nxt >= ITER_MIN)) begin
                        state_d = S_OUT;
                        early_d = 1'b1;
                    end else if (iter_nxt == ITER_MAX) begin
                        state_d = S_OUT;
                        early_d = 1'b0;
                    end else begin
                        state_d = S_HALF1;
                        k_d     = '0;
                    end
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_load_en   = (state_q == S_LOAD) && i_data_valid;
        o_load_bank = (state_q == S_LOAD) ? bank_q : 2'd0;
        o_load_addr = (state_q == S_LOAD) ? laddr_q : '0;
        o_siso_en   = (state_q == S_HALF1) || (state_q == S_HALF2);
        o_siso_sel  = (state_q == S_HALF2);
        o_siso_addr = (state_q == S_HALF1) ? k_q :
                      (state_q == S_HALF2) ? pi_q : '0;
        o_iter_cnt  = iter_q;
        o_done      = (state_q == S_OUT);
        o_early     = (state_q == S_OUT) && early_q;
    end

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Randomized self-checking bench for turbo_iter_ctrl against a frame-level
// reference model derived from the load / sweep / termination rules.
module tb_turbo_iter_ctrl;

    localparam int K        = 16;
    localparam int ADDR_W   = 4;
    localparam int MAX_ITER = 16;
    localparam int MIN_ITER = 2;
    localparam int ILV_P    = 5;
    localparam int ILV_OFS  = 3;
    localparam int ITER_W   = 5;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_start;
    logic              i_data_valid;
    logic              i_siso_done;
    logic              i_hard_match;
    logic              o_busy;
    logic              o_load_en;
    logic [1:0]        o_load_bank;
    logic [ADDR_W-1:0] o_load_addr;
    logic              o_siso_en;
    logic              o_siso_sel;
    logic [ADDR_W-1:0] o_siso_addr;
    logic [ITER_W-1:0] o_iter_cnt;
    logic              o_done;
    logic              o_early;

    int n_chk  = 0;
    int n_fail = 0;

    turbo_iter_ctrl #(
        .K(K), .ADDR_W(ADDR_W), .MAX_ITER(MAX_ITER), .MIN_ITER(MIN_ITER),
        .ILV_P(ILV_P), .ILV_OFS(ILV_OFS), .ITER_W(ITER_W)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_data_valid(i_data_valid), .i_siso_done(i_siso_done),
        .i_hard_match(i_hard_match), .o_busy(o_busy), .o_load_en(o_load_en),
        .o_load_bank(o_load_bank), .o_load_addr(o_load_addr),
        .o_siso_en(o_siso_en), .o_siso_sel(o_siso_sel),
        .o_siso_addr(o_siso_addr), .o_iter_cnt(o_iter_cnt),
        .o_done(o_done), .o_early(o_early)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk_eq({pfx, "_busy"},      o_busy, 0);
        chk_eq({pfx, "_load_en"},   o_load_en, 0);
        chk_eq({pfx, "_load_bank"}, o_load_bank, 0);
        chk_eq({pfx, "_load_addr"}, o_load_addr, 0);
        chk_eq({pfx, "_siso_en"},   o_siso_en, 0);
        chk_eq({pfx, "_siso_sel"},  o_siso_sel, 0);
        chk_eq({pfx, "_siso_addr"}, o_siso_addr, 0);
        chk_eq({pfx, "_iter_cnt"},  o_iter_cnt, 0);
        chk_eq({pfx, "_done"},      o_done, 0);
        chk_eq({pfx, "_early"},     o_early, 0);
    endtask

    // Drives one frame from the IDLE cycle and checks every cycle against the
    // model. vmode: 0 valid always, 1 valid every other cycle, 2 random.
    // pct: probability (%) of hard_match at each WAIT2 done. abort_k >= 0
    // asserts reset during the first HALF2 at that k.
    task automatic run_frame(input int vmode, input int pct, input int dly_max,
                             input int abort_k, output int lat, output int n_out,
                             output int early_out);
        int  cnt, guard, n, dly;
        bit  v, m, fin, exp_early;
        lat = 1;
        n_out = 0;
        early_out = 0;
        exp_early = 0;

        i_start = 1'b1;
        i_data_valid = 1'($urandom_range(0, 1));
        i_siso_done = 1'b0;
        i_hard_match = 1'($urandom_range(0, 1));
        #2;
        chk_eq("idle_busy", o_busy, 0);
        chk_eq("idle_done", o_done, 0);
        chk_eq("idle_load_en", o_load_en, 0);
        next_cycle(); lat++;

        cnt = 0;
        guard = 0;
        while (cnt < 3 * K && guard < 4000) begin
            if (vmode == 0)      v = 1'b1;
            else if (vmode == 1) v = (guard % 2 == 0);
            else                 v = 1'($urandom_range(0, 1));
            i_data_valid = v;
            i_start      = ($urandom_range(0, 3) == 0);
            i_siso_done  = ($urandom_range(0, 3) == 0);
            #2;
            chk_eq("load_busy", o_busy, 1);
            chk_eq("load_en", o_load_en, int'(v));
            chk_eq("load_bank", o_load_bank, cnt / K);
            chk_eq("load_addr", o_load_addr, cnt % K);
            chk_eq("load_siso_en", o_siso_en, 0);
            if (v) cnt++;
            guard++;
            next_cycle(); lat++;
        end
        if (cnt < 3 * K) chk_eq("load_timeout", cnt, 3 * K);

        n = 0;
        fin = 0;
        while (!fin) begin
            for (int k = 0; k < K; k++) begin
                i_start      = ($urandom_range(0, 3) == 0);
                i_siso_done  = ($urandom_range(0, 3) == 0);
                i_data_valid = 1'($urandom_range(0, 1));
                i_hard_match = 1'($urandom_range(0, 1));
                #2;
                chk_eq("h1_en", o_siso_en, 1);
                chk_eq("h1_sel", o_siso_sel, 0);
                chk_eq("h1_addr", o_siso_addr, k);
                chk_eq("h1_iter", o_iter_cnt, n);
                chk_eq("h1_load_en", o_load_en, 0);
                next_cycle(); lat++;
            end
            dly = $urandom_range(0, dly_max);
            for (int d = 0; d <= dly; d++) begin
                i_siso_done = (d == dly);
                i_start     = ($urandom_range(0, 1) == 0);
                #2;
                chk_eq("w1_en", o_siso_en, 0);
                chk_eq("w1_busy", o_busy, 1);
                chk_eq("w1_done", o_done, 0);
                next_cycle(); lat++;
            end
            for (int k = 0; k < K; k++) begin
                i_start     = ($urandom_range(0, 3) == 0);
                i_siso_done = ($urandom_range(0, 3) == 0);
                #2;
                chk_eq("h2_en", o_siso_en, 1);
                chk_eq("h2_sel", o_siso_sel, 1);
                chk_eq("h2_addr", o_siso_addr, (ILV_P * k + ILV_OFS) % K);
                chk_eq("h2_iter", o_iter_cnt, n);
                if (n == 0 && k == abort_k) begin
                    #1;
                    i_rst_n = 1'b0;
                    #1;
                    chk_all_zero("rst_async");
                    return;
                end
                next_cycle(); lat++;
            end
            dly = $urandom_range(0, dly_max);
            m = ($urandom_range(0, 99) < pct);
            for (int d = 0; d <= dly; d++) begin
                i_siso_done  = (d == dly);
                i_hard_match = (d == dly) ? m : 1'($urandom_range(0, 1));
                i_start      = 1'($urandom_range(0, 1));
                #2;
                chk_eq("w2_en", o_siso_en, 0);
                chk_eq("w2_iter", o_iter_cnt, n);
                chk_eq("w2_done", o_done, 0);
                next_cycle(); lat++;
            end
            n++;
            if (m && n >= MIN_ITER) begin
                exp_early = 1; fin = 1;
            end else if (n == MAX_ITER) begin
                exp_early = 0; fin = 1;
            end
        end

        i_start     = 1'($urandom_range(0, 1));
        i_siso_done = 1'($urandom_range(0, 1));
        #2;
        chk_eq("out_done", o_done, 1);
        chk_eq("out_early", o_early, int'(exp_early));
        chk_eq("out_iter", o_iter_cnt, n);
        chk_eq("out_busy", o_busy, 1);
        chk_eq("out_siso_en", o_siso_en, 0);
        n_out = o_iter_cnt;
        early_out = o_early;
        next_cycle();

        i_start = 1'b0;
        #2;
        chk_eq("post_done", o_done, 0);
        chk_eq("post_busy", o_busy, 0);
        chk_eq("post_iter_hold", o_iter_cnt, n);
        next_cycle();
    endtask

    initial begin
        int lat, n_out, e_out;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_data_valid = 1'b0;
        i_siso_done = 1'b0;
        i_hard_match = 1'b0;
        #12;
        chk_all_zero("reset");
        #10;
        i_rst_n = 1'b1;
        next_cycle();

        // Immediate dones, match always: stops at MIN_ITER with early, minimum latency.
        run_frame(0, 100, 0, -1, lat, n_out, e_out);
        chk_eq("min_latency", lat, 1 + 3 * K + MIN_ITER * (2 * K + 2) + 1);
        chk_eq("min_iter_cnt", n_out, MIN_ITER);
        chk_eq("min_early", e_out, 1);

        // Toggling valid, never matching: runs to MAX_ITER without early stop.
        run_frame(1, 0, 0, -1, lat, n_out, e_out);
        chk_eq("max_iter_cnt", n_out, MAX_ITER);
        chk_eq("max_early", e_out, 0);

        // Reset during the first HALF2 at k=7 abandons the frame.
        run_frame(0, 0, 0, 7, lat, n_out, e_out);
        i_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            chk_eq("rst_hold_busy", o_busy, 0);
        end
        i_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            chk_eq("rst_after_done", o_done, 0);
            chk_eq("rst_after_busy", o_busy, 0);
            chk_eq("rst_after_iter", o_iter_cnt, 0);
        end

        run_frame(0, 50, 2, -1, lat, n_out, e_out);
        for (int f = 0; f < 4; f++) begin
            run_frame(2, 30, 3, -1, lat, n_out, e_out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
